// File: rtl/cpu_ctrl_gen2.sv
// Control FSM for the bitty CPU: reg-reg / reg-imm ALU, conditional branch and load/store with req/ack.
// Optional memory-wait abort is enabled by defining CTRL_TIMEOUT_EN. DATA_W must be at least 13.
module cpu_ctrl_gen2 #(
    parameter int DATA_W      = 16,
    parameter int IMM_SIGNED  = 0,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [15:0]       d_inst,
    input  logic              flag_eq,
    input  logic              flag_gt,
    input  logic              flag_lt,
    input  logic              mem_ack,
    output logic              en_inst,
    output logic              en_s,
    output logic              en_c,
    output logic [7:0]        en,
    output logic [2:0]        sel,
    output logic [3:0]        mux_sel,
    output logic [DATA_W-1:0] im_d,
    output logic              en_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_target,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADA = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        MADDR = 3'd4,
        MEM   = 3'd5,
        BR    = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] inst_r;
    logic [2:0]  rx_s;
    logic [2:0]  ry_s;
    logic [1:0]  fmt_s;
    logic        ls_illegal_s;
    logic        wb_err_s;
    logic        imm_ext_s;
    logic        expire_s;
    logic        timeout_r;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    function automatic logic cond_true(input logic [1:0] cond, input logic eq,
                                       input logic gt, input logic lt);
        logic res;
        case (cond)
            2'b00:   res = 1'b1;
            2'b01:   res = eq;
            2'b10:   res = gt;
            2'b11:   res = lt;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    assign rx_s         = inst_r[15:13];
    assign ry_s         = inst_r[12:10];
    assign fmt_s        = inst_r[1:0];
    assign ls_illegal_s = (fmt_s == 2'b11) && inst_r[3];
    assign wb_err_s     = ls_illegal_s || timeout_r;
    assign imm_ext_s    = (IMM_SIGNED != 0) ? inst_r[12] : 1'b0;
    assign im_d         = {{(DATA_W-8){imm_ext_s}}, inst_r[12:5]};
    assign pc_target    = {{(DATA_W-12){1'b0}}, inst_r[15:4]};

`ifdef CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_r;

    assign expire_s = (state_r == MEM) && !mem_ack && (cnt_r == CNT_W'(MEM_TIMEOUT - 1));

    // Memory wait counter: cleared in MADDR so it starts at zero on MEM entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == MADDR) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == MEM) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Abort flag carried from MEM into WB; cleared once back in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_r <= 1'b0;
        end else if (state_r == IDLE) begin
            timeout_r <= 1'b0;
        end else if (expire_s) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end
`else
    assign expire_s  = 1'b0;
    assign timeout_r = 1'b0;
`endif

    // State and instruction registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            inst_r  <= 16'h0000;
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && run) begin
                inst_r <= d_inst;
            end else begin
                inst_r <= inst_r;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (run) begin
                    case (d_inst[1:0])
                        2'b00:   state_s = LOADA;
                        2'b01:   state_s = LOADA;
                        2'b10:   state_s = BR;
                        2'b11:   state_s = MADDR;
                        default: state_s = IDLE;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            LOADA: state_s = EXEC;
            EXEC:  state_s = WB;
            MADDR: begin
                if (inst_r[3]) begin
                    state_s = WB;
                end else begin
                    state_s = MEM;
                end
            end
            MEM: begin
                if (mem_ack || expire_s) begin
                    state_s = WB;
                end else begin
                    state_s = MEM;
                end
            end
            BR:      state_s = WB;
            WB:      state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Moore output decode from state and latched instruction (flags feed pc_load in BR).
    always_comb begin
        en_inst = 1'b0;
        en_s    = 1'b0;
        en_c    = 1'b0;
        en      = 8'h00;
        sel     = 3'd0;
        mux_sel = 4'd9;
        en_addr = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        pc_load = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state_r)
            IDLE: en_inst = 1'b1;
            LOADA: begin
                en_s    = 1'b1;
                mux_sel = {1'b0, rx_s};
            end
            EXEC: begin
                en_c = 1'b1;
                sel  = inst_r[4:2];
                if (fmt_s == 2'b00) begin
                    mux_sel = {1'b0, ry_s};
                end else begin
                    mux_sel = 4'd8;
                end
            end
            MADDR: begin
                en_addr = 1'b1;
                mux_sel = {1'b0, ry_s};
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = inst_r[2];
                if (inst_r[2]) begin
                    mux_sel = {1'b0, rx_s};
                end else begin
                    mux_sel = 4'd9;
                end
            end
            BR: pc_load = cond_true(inst_r[3:2], flag_eq, flag_gt, flag_lt);
            WB: begin
                done = 1'b1;
                err  = wb_err_s;
                if (!fmt_s[1]) begin
                    en = onehot8(rx_s);
                end else if ((fmt_s == 2'b11) && !wb_err_s && !inst_r[2]) begin
                    en      = onehot8(rx_s);
                    mux_sel = 4'd10;
                end else begin
                    en = 8'h00;
                end
            end
            default: begin
                en_inst = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_gen2.sv
// Bench for cpu_ctrl_gen2: table of instructions pushed to a scoreboard, monitor pops and checks on done.
module tb_cpu_ctrl_gen2;
    localparam int DW  = 16;
    localparam int TMO = 8;
    localparam logic [23:0] RST_OUTS = {1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 4'd9, 6'b000000};

    logic          clk = 1'b0;
    logic          reset, run, flag_eq, flag_gt, flag_lt, mem_ack;
    logic [15:0]   d_inst;
    logic          en_inst, en_s, en_c, en_addr, mem_req, mem_we, pc_load, done, err;
    logic [7:0]    en;
    logic [2:0]    sel;
    logic [3:0]    mux_sel;
    logic [DW-1:0] im_d, pc_target;
    logic          s_en_inst, s_en_s, s_en_c, s_en_addr, s_mem_req, s_mem_we, s_pc_load, s_done, s_err;
    logic [7:0]    s_en;
    logic [2:0]    s_sel;
    logic [3:0]    s_mux_sel;
    logic [DW-1:0] s_im_d, s_pc_target;

    typedef struct {
        logic [15:0] inst;
        logic [2:0]  flags;
        int          ack_wait;
        int          lat;
        logic [7:0]  en;
        logic        err;
        logic [3:0]  wb_mux;
        logic        pc_load;
        int          mreq;
        logic        we;
        logic [15:0] imd_u;
        logic [15:0] imd_s;
    } vec_t;

    typedef struct {
        vec_t v;
        int   exp_cyc;
    } sb_t;

    sb_t  sb_q[$];
    vec_t tbl[13];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    cpu_ctrl_gen2 #(.DATA_W(DW), .IMM_SIGNED(0), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .run(run), .d_inst(d_inst),
        .flag_eq(flag_eq), .flag_gt(flag_gt), .flag_lt(flag_lt), .mem_ack(mem_ack),
        .en_inst(en_inst), .en_s(en_s), .en_c(en_c), .en(en), .sel(sel), .mux_sel(mux_sel),
        .im_d(im_d), .en_addr(en_addr), .mem_req(mem_req), .mem_we(mem_we),
        .pc_load(pc_load), .pc_target(pc_target), .done(done), .err(err)
    );

    cpu_ctrl_gen2 #(.DATA_W(DW), .IMM_SIGNED(1), .MEM_TIMEOUT(TMO)) dut_s (
        .clk(clk), .reset(reset), .run(run), .d_inst(d_inst),
        .flag_eq(flag_eq), .flag_gt(flag_gt), .flag_lt(flag_lt), .mem_ack(mem_ack),
        .en_inst(s_en_inst), .en_s(s_en_s), .en_c(s_en_c), .en(s_en), .sel(s_sel), .mux_sel(s_mux_sel),
        .im_d(s_im_d), .en_addr(s_en_addr), .mem_req(s_mem_req), .mem_we(s_mem_we),
        .pc_load(s_pc_load), .pc_target(s_pc_target), .done(s_done), .err(s_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] outs();
        return {en_inst, en_s, en_c, en, sel, mux_sel, en_addr, mem_req, mem_we, pc_load, done, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input logic hold_ack);
        sb_t e;
        int  start;
        int  mcount;
        d_inst = v.inst;
        {flag_eq, flag_gt, flag_lt} = v.flags;
        run     = 1'b1;
        mem_ack = hold_ack;
        e.v       = v;
        e.exp_cyc = cyc + v.lat;
        sb_q.push_back(e);
        start  = done_cnt;
        mcount = 0;
        tick();
        run = 1'b0;
        for (int n = 0; n < 40 && done_cnt == start; n++) begin
            if (mem_req) begin
                mcount++;
                mem_ack = (mcount == v.ack_wait);
            end else begin
                mem_ack = hold_ack;
            end
            tick();
        end
        chk("done_seen", done_cnt - start, 1);
        mem_ack = 1'b0;
    endtask

    // Monitor: per-cycle invariants, per-state bus checks and scoreboard pop on done.
    initial begin
        int   mreq_cnt;
        logic we_seen, pl_seen;
        vec_t cur;
        sb_t  e;
        mreq_cnt = 0;
        we_seen  = 1'b0;
        pl_seen  = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mreq_cnt = 0;
                we_seen  = 1'b0;
                pl_seen  = 1'b0;
            end else begin
                chk("exclusive", ($countones({en_s, en_c, en_addr, mem_req, pc_load}) <= 1), 1);
                chk("en_onehot0", $onehot0(en), 1);
                if (sb_q.size() > 0) begin
                    cur = sb_q[0].v;
                    if (en_s) chk("loada_mux", mux_sel, {1'b0, cur.inst[15:13]});
                    if (en_c) begin
                        chk("exec_sel", sel, cur.inst[4:2]);
                        chk("exec_mux", mux_sel, (cur.inst[1:0] == 2'b00) ? {1'b0, cur.inst[12:10]} : 4'd8);
                    end
                    if (en_addr) chk("maddr_mux", mux_sel, {1'b0, cur.inst[12:10]});
                    if (mem_req) chk("mem_mux", mux_sel, cur.inst[2] ? {1'b0, cur.inst[15:13]} : 4'd9);
                end
                if (mem_req) begin
                    mreq_cnt++;
                    we_seen = we_seen | mem_we;
                end
                if (pc_load) pl_seen = 1'b1;
                if (done) begin
                    if (sb_q.size() == 0) begin
                        chk("spurious_done", done, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("latency", cyc, e.exp_cyc);
                        chk("wb_en", en, e.v.en);
                        chk("wb_err", err, e.v.err);
                        chk("wb_mux", mux_sel, e.v.wb_mux);
                        chk("pc_load", pl_seen, e.v.pc_load);
                        chk("pc_target", pc_target, {4'h0, e.v.inst[15:4]});
                        chk("mem_req_cycles", mreq_cnt, e.v.mreq);
                        chk("mem_we", we_seen, e.v.we);
                        chk("im_d_zext", im_d, e.v.imd_u);
                        chk("im_d_sext", s_im_d, e.v.imd_s);
                    end
                    mreq_cnt = 0;
                    we_seen  = 1'b0;
                    pl_seen  = 1'b0;
                    done_cnt++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tv;
        //            inst      flags   ackw lat en     err   mux    pcl   mreq we    imd_u     imd_s
        tbl[0]  = '{16'h540C, 3'b000, 0, 3, 8'h04, 1'b0, 4'd9,  1'b0, 0, 1'b0, 16'h00A0, 16'hFFA0};
        tbl[1]  = '{16'h3E01, 3'b000, 0, 3, 8'h02, 1'b0, 4'd9,  1'b0, 0, 1'b0, 16'h00F0, 16'hFFF0};
        tbl[2]  = '{16'h1236, 3'b100, 0, 2, 8'h00, 1'b0, 4'd9,  1'b1, 0, 1'b0, 16'h0091, 16'hFF91};
        tbl[3]  = '{16'h1236, 3'b011, 0, 2, 8'h00, 1'b0, 4'd9,  1'b0, 0, 1'b0, 16'h0091, 16'hFF91};
        tbl[4]  = '{16'h9803, 3'b000, 4, 6, 8'h10, 1'b0, 4'd10, 1'b0, 4, 1'b0, 16'h00C0, 16'hFFC0};
        tbl[5]  = '{16'h9807, 3'b000, 2, 4, 8'h00, 1'b0, 4'd9,  1'b0, 2, 1'b1, 16'h00C0, 16'hFFC0};
        tbl[6]  = '{16'h980B, 3'b000, 0, 2, 8'h00, 1'b1, 4'd9,  1'b0, 0, 1'b0, 16'h00C0, 16'hFFC0};
        tbl[7]  = '{16'hABCA, 3'b010, 0, 2, 8'h00, 1'b0, 4'd9,  1'b1, 0, 1'b0, 16'h005E, 16'h005E};
        tbl[8]  = '{16'hABCE, 3'b010, 0, 2, 8'h00, 1'b0, 4'd9,  1'b0, 0, 1'b0, 16'h005E, 16'h005E};
        tbl[9]  = '{16'h0002, 3'b000, 0, 2, 8'h00, 1'b0, 4'd9,  1'b1, 0, 1'b0, 16'h0000, 16'h0000};
        tbl[10] = '{16'hE000, 3'b000, 0, 3, 8'h80, 1'b0, 4'd9,  1'b0, 0, 1'b0, 16'h0000, 16'h0000};
        tbl[11] = '{16'h0001, 3'b000, 0, 3, 8'h01, 1'b0, 4'd9,  1'b0, 0, 1'b0, 16'h0000, 16'h0000};
        tbl[12] = '{16'h9803, 3'b000, 1, 3, 8'h10, 1'b0, 4'd10, 1'b0, 1, 1'b0, 16'h00C0, 16'hFFC0};

        reset   = 1'b0;
        run     = 1'b0;
        d_inst  = 16'h0000;
        flag_eq = 1'b0;
        flag_gt = 1'b0;
        flag_lt = 1'b0;
        mem_ack = 1'b0;
        #2;
        chk("rst_outs", outs(), RST_OUTS);
        chk("rst_imd_pc", {im_d, pc_target}, 32'h0000_0000);
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("idle_hold", outs(), RST_OUTS);

        // First vector runs with mem_ack held high to show it is ignored outside MEM.
        for (int i = 0; i < 13; i++) begin
            run_vec(tbl[i], (i == 0));
        end

        // Reset asserted in the middle of a memory wait.
        d_inst = 16'h9803;
        run    = 1'b1;
        tick();
        run = 1'b0;
        for (int n = 0; n < 10 && !mem_req; n++) tick();
        chk("mem_req_before_rst", mem_req, 1);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_async_outs", outs(), RST_OUTS);
        tick();
        tick();
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("post_rst_idle", outs(), RST_OUTS);
        end
        run_vec(tbl[0], 1'b0);

`ifdef CTRL_TIMEOUT_EN
        tv = '{16'h9803, 3'b000, 0, 2 + TMO, 8'h00, 1'b1, 4'd9, 1'b0, TMO, 1'b0, 16'h00C0, 16'hFFC0};
        run_vec(tv, 1'b0);
        run_vec(tbl[1], 1'b0);
`else
        tv = tbl[1];
        run_vec(tv, 1'b0);
`endif

        tick();
        tick();
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_gen2.md
Name: cpu_ctrl_gen2

Overview:
Parametrised second-generation control FSM for the bitty CPU. It latches a 16-bit instruction and drives register-file, ALU and bus-mux controls for four formats: reg-reg ALU, reg-imm ALU, conditional branch, and load/store with a memory req/ack handshake. Data width and immediate extension are parametrised. It sits between instruction fetch and the datapath (register file, S/C registers, ALU, bus mux).

Parameters:
DATA_W, 16, width of im_d, pc_target and the datapath bus
IMM_SIGNED, 0, 1 = sign-extend imm8 onto im_d, 0 = zero-extend
MEM_TIMEOUT, 255, cycles MEM waits for mem_ack before abort (only with CTRL_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
run  in  1  start request, sampled in IDLE only
d_inst  in  16  instruction; [15:13] rx, [12:10] ry, [12:5] imm8, [4:2] alu sel / branch cond / ls bits, [1:0] format
flag_eq, flag_gt, flag_lt  in  1 each  compare flags from datapath
mem_ack  in  1  memory completes the transfer
en_inst  out  1  instruction register enable (high in IDLE)
en_s  out  1  load S register
en_c  out  1  load C register
en  out  8  one-hot register-file write enable
sel  out  3  ALU op select
mux_sel  out  4  bus source: 0-7 reg, 8 im_d, 9 zero/default, 10 memory read data
im_d  out  DATA_W  extended imm8 of latched instruction
en_addr  out  1  load memory address register from bus
mem_req  out  1  memory request
mem_we  out  1  1 = store
pc_load  out  1  branch taken, load PC
pc_target  out  DATA_W  zero-extended inst_q[15:4]
done  out  1  one-cycle completion pulse
err  out  1  qualifies done: aborted/illegal instruction

Behaviour:
- States: IDLE, LOADA, EXEC, WB, MADDR, MEM, BR. Outputs decode from state and inst_q.
- Reset (async, low): state IDLE, inst_q 0, timeout counter 0. All outputs 0, except mux_sel = 9 and en_inst = 1 (IDLE decode).
- IDLE: en_inst = 1. On run = 1: inst_q <= d_inst. Next state by format: 00/01 -> LOADA, 10 -> BR, 11 -> MADDR. run = 0 stays IDLE. run outside IDLE is ignored.
- LOADA: en_s = 1, mux_sel = rx -> EXEC.
- EXEC: en_c = 1, sel = inst_q[4:2], mux_sel = ry (fmt 00) or 8 (fmt 01) -> WB.
- MADDR: mux_sel = ry, en_addr = 1 -> MEM. If inst_q[3] = 1 (reserved), go to WB with err.
- MEM: mem_req = 1, mem_we = inst_q[2]. mux_sel = rx for store, else 9. Hold all outputs while mem_ack = 0. mem_ack = 1 -> WB.
- BR: cond inst_q[3:2]: 00 always, 01 flag_eq, 10 flag_gt, 11 flag_lt. pc_load = cond true, pc_target valid -> WB.
- WB: done = 1 for exactly one cycle -> IDLE.
  - ALU formats: en[rx] = 1.
  - Load: en[rx] = 1, mux_sel = 10.
  - Store, branch, error: en = 0.
- im_d is a function of inst_q in every state (extension per IMM_SIGNED).
- Latency from accept edge to done: ALU 3 cycles, branch 2 cycles, load/store 3 + wait cycles.
- At most one bit of en is high at a time. en_s, en_c, en_addr, mem_req and pc_load are mutually exclusive.
- Reset asserted mid-instruction: abort immediately. No done, mem_req drops asynchronously.
- mem_ack outside MEM is ignored.

Optional Feature:
CTRL_TIMEOUT_EN:
- Defined: counter clears on MEM entry and increments each cycle in MEM. When it reaches MEM_TIMEOUT without mem_ack, go to WB with en = 0 and err = 1 alongside done. mem_ack on the same cycle as expiry wins (normal completion).
- Undefined: MEM waits indefinitely, err is only driven by illegal load/store, no counter logic.

Test Plan:
- 0x540C + run pulse -> LOADA mux_sel = 2, en_s; EXEC mux_sel = 5, sel = 3, en_c; WB en = 8'h04, done. done is 3 cycles after accept.
- 0x3E01: IMM_SIGNED = 0 -> im_d = 0x00F0; IMM_SIGNED = 1 -> im_d = 0xFFF0. EXEC mux_sel = 8, WB en = 8'h02.
- 0x1236 with flag_eq = 1 -> BR pc_load = 1, pc_target = 0x0123, then done. With flag_eq = 0 -> pc_load = 0, done still pulses.
- 0x9803 (load) with mem_ack after 4 cycles -> MADDR mux_sel = 6, en_addr; mem_req held 4 cycles, mem_we = 0; WB mux_sel = 10, en = 8'h10. 0x9807 (store) -> mem_we = 1, mux_sel = 4 during MEM, en = 0.
- CTRL_TIMEOUT_EN, MEM_TIMEOUT = 8, no mem_ack -> mem_req for 8 cycles, then done = 1 with err = 1, en = 0. Next run is accepted normally.
- reset low during MEM -> outputs at reset values asynchronously, mem_req = 0, no done. After release, run = 0 keeps IDLE, and run with d_inst = 0x540C completes normally.
